// File: rtl/day_of_week_sequencer.sv
// -----------------------------------------------------------------------------
// day_of_week_sequencer
//
// Multi-cycle day-of-week calculator for a Gregorian calendar date. A single
// restoring-divider datapath is reused twice: first to form (Years-1)/100,
// then to reduce the accumulated day count modulo 7. Latency is fixed and
// does not depend on the date, so downstream display/alarm logic can rely on
// a constant Start-to-Done distance.
//
// Ports:
//   Clk        system clock, rising-edge active
//   nReset     asynchronous active-low reset
//   Start      request strobe, accepted in IDLE or in the Done cycle
//   Days       day of month (1..31)
//   Months     month (1..12)
//   Years      year (>= 1)
//   Leap       high when Years is a leap year
//   Busy       high while a request is in flight
//   Done       one-cycle completion pulse
//   Error      valid with Done, high when the date was rejected
//   DayOfWeek  0=Sunday .. 6=Saturday, valid with Done when Error is low
// -----------------------------------------------------------------------------
module day_of_week_sequencer #(
  parameter int YEAR_W = 15,
  parameter int SUM_W  = 17
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              Start,
  input  logic [6:0]        Days,
  input  logic [6:0]        Months,
  input  logic [YEAR_W-1:0] Years,
  input  logic              Leap,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [2:0]        DayOfWeek
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_DIV100 = 3'd2;
  localparam logic [2:0] S_ACC    = 3'd3;
  localparam logic [2:0] S_MOD7   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int CNT_W = $clog2(SUM_W) + 1;

  // Architectural state
  logic [2:0]        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [6:0]        days_r;
  logic [6:0]        months_r;
  logic [YEAR_W-1:0] years_r;
  logic              leap_r;
  logic              bad_r;
  logic [SUM_W-1:0]  shift_r;
  logic [6:0]        rem_r;
  logic              busy_r;
  logic              done_r;
  logic              error_r;
  logic [2:0]        dow_r;

  // Combinational helpers
  logic [YEAR_W-1:0] ySub_s;
  logic [6:0]        monthLen_s;
  logic              bad_s;
  logic [SUM_W-1:0]  monBase_s;
  logic [SUM_W-1:0]  monAdj_s;
  logic [SUM_W-1:0]  monHalf_s;
  logic [SUM_W-1:0]  monOff_s;
  logic [YEAR_W-1:0] q100_s;
  logic [SUM_W-1:0]  sum_s;
  logic [SUM_W-1:0]  divLoad_s;
  logic [7:0]        divisor_s;
  logic [7:0]        trial_s;
  logic              geq_s;
  logic [6:0]        remNext_s;
  logic [SUM_W-1:0]  shiftNext_s;

  assign Busy      = busy_r;
  assign Done      = done_r;
  assign Error     = error_r;
  assign DayOfWeek = dow_r;

  assign ySub_s = years_r - YEAR_W'(1'b1);

  // Length of the latched month, February depending on the leap flag
  always_comb begin
    monthLen_s = 7'd31;
    case (months_r)
      7'd2:                    monthLen_s = leap_r ? 7'd29 : 7'd28;
      7'd4, 7'd6, 7'd9, 7'd11: monthLen_s = 7'd30;
      default:                 monthLen_s = 7'd31;
    endcase
  end

  assign bad_s = (days_r == 7'd0) || (months_r == 7'd0) || (months_r > 7'd12) ||
                 (years_r == YEAR_W'(1'b0)) || (days_r > monthLen_s);

  // Days preceding the first of the month: 30 per month, corrected for the
  // short February and for the 31-day months (odd before August, even after)
  always_comb begin
    monBase_s = SUM_W'(months_r - 7'd1) * SUM_W'(5'd30);
    if (months_r < 7'd3) begin
      monAdj_s = SUM_W'(1'b0);
    end else if (leap_r) begin
      monAdj_s = SUM_W'(1'b1);
    end else begin
      monAdj_s = SUM_W'(2'd2);
    end
    if (months_r <= 7'd8) begin
      monHalf_s = SUM_W'(months_r >> 1);
    end else begin
      monHalf_s = SUM_W'((months_r + 7'd1) >> 1);
    end
    monOff_s = monBase_s - monAdj_s + monHalf_s;
  end

  // After DIV100 the low YEAR_W bits of the shift register hold the quotient.
  // 365 = 1 mod 7, so whole years contribute only Y plus the leap days.
  assign q100_s = shift_r[YEAR_W-1:0];
  assign sum_s  = SUM_W'(days_r) + monOff_s + SUM_W'(ySub_s) + SUM_W'(ySub_s >> 2)
                - SUM_W'(q100_s) + SUM_W'(q100_s >> 2);

  // Y is left-aligned so both phases consume dividend bits from the MSB
  assign divLoad_s = SUM_W'(ySub_s) << (SUM_W - YEAR_W);

  // Shared restoring divider step: divisor selected by phase
  always_comb begin
    if (state_r == S_MOD7) begin
      divisor_s = 8'd7;
    end else begin
      divisor_s = 8'd100;
    end
    trial_s = {rem_r, shift_r[SUM_W-1]};
    geq_s   = (trial_s >= divisor_s);
    // The restored remainder is always below the divisor, so 7 bits suffice
    if (geq_s) begin
      remNext_s = 7'(trial_s - divisor_s);
    end else begin
      remNext_s = trial_s[6:0];
    end
    shiftNext_s = {shift_r[SUM_W-2:0], geq_s};
  end

  // Sequencer FSM, operand capture and divider datapath registers
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_r  <= S_IDLE;
      cnt_r    <= CNT_W'(1'b0);
      days_r   <= 7'd0;
      months_r <= 7'd0;
      years_r  <= YEAR_W'(1'b0);
      leap_r   <= 1'b0;
      bad_r    <= 1'b0;
      shift_r  <= SUM_W'(1'b0);
      rem_r    <= 7'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      error_r  <= 1'b0;
      dow_r    <= 3'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE: begin
          if (Start) begin
            days_r   <= Days;
            months_r <= Months;
            years_r  <= Years;
            leap_r   <= Leap;
            busy_r   <= 1'b1;
            error_r  <= 1'b0;
            cnt_r    <= CNT_W'(1'b0);
            state_r  <= S_CHECK;
          end else begin
            state_r  <= state_r;
          end
        end
        // First CHECK cycle registers the verdict, second one acts on it
        S_CHECK: begin
          if (cnt_r == CNT_W'(1'b0)) begin
            bad_r <= bad_s;
            cnt_r <= CNT_W'(1'b1);
          end else if (bad_r) begin
            error_r <= 1'b1;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= S_DONE;
          end else begin
            shift_r <= divLoad_s;
            rem_r   <= 7'd0;
            cnt_r   <= CNT_W'(1'b0);
            state_r <= S_DIV100;
          end
        end
        S_DIV100: begin
          shift_r <= shiftNext_s;
          rem_r   <= remNext_s;
          if (cnt_r == CNT_W'(YEAR_W - 1)) begin
            state_r <= S_ACC;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        S_ACC: begin
          shift_r <= sum_s;
          rem_r   <= 7'd0;
          cnt_r   <= CNT_W'(1'b0);
          state_r <= S_MOD7;
        end
        S_MOD7: begin
          shift_r <= shiftNext_s;
          rem_r   <= remNext_s;
          if (cnt_r == CNT_W'(SUM_W - 1)) begin
            dow_r   <= remNext_s[2:0];
            error_r <= 1'b0;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= S_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_day_of_week_sequencer.sv
// -----------------------------------------------------------------------------
// tb_day_of_week_sequencer
//
// Directed and random checks of day_of_week_sequencer: reset state, valid
// and rejected dates, abort by reset, the largest year, Start handshake and a
// back-to-back random sweep against an independent day-of-week formula.
// -----------------------------------------------------------------------------
module tb_day_of_week_sequencer;

  logic        Clk = 1'b0;
  logic        nReset;
  logic        Start;
  logic [6:0]  Days;
  logic [6:0]  Months;
  logic [14:0] Years;
  logic        Leap;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [2:0]  DayOfWeek;

  int testsRun    = 0;
  int testsFailed = 0;
  logic [2:0] lastDow;

  always #5 Clk = ~Clk;

  day_of_week_sequencer #(.YEAR_W(15), .SUM_W(17)) dut (
    .Clk(Clk), .nReset(nReset), .Start(Start), .Days(Days), .Months(Months),
    .Years(Years), .Leap(Leap), .Busy(Busy), .Done(Done), .Error(Error),
    .DayOfWeek(DayOfWeek)
  );

  // Sakamoto's method, proleptic Gregorian, 0 = Sunday
  function automatic logic [2:0] goldenDow(input int d, input int m, input int y);
    int t[12] = '{0, 3, 2, 5, 0, 3, 5, 1, 4, 6, 2, 4};
    int yy;
    yy = (m < 3) ? y - 1 : y;
    return 3'((yy + yy / 4 - yy / 100 + yy / 400 + t[m-1] + d) % 7);
  endfunction

  function automatic logic isLeap(input int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int monLen(input int m, input logic l);
    if (m == 2) return l ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  // Present a request at the next falling edge; returns Busy/Done just after E0
  task automatic issue(input int d, input int m, input int y, input logic l,
                       output logic busyE0, output logic doneE0);
    @(negedge Clk);
    Days = 7'(d); Months = 7'(m); Years = 15'(y); Leap = l; Start = 1'b1;
    @(posedge Clk);
    #1;
    busyE0 = Busy;
    doneE0 = Done;
    @(negedge Clk);
    Start = 1'b0;
    Days = 7'h7F; Months = 7'd0; Years = 15'h7FFF; Leap = ~l;
  endtask

  // Edges after E0 until Done is seen; -1 if the budget runs out
  task automatic waitDone(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge Clk);
      #1;
      if (Done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    testsRun++;
    if ({Busy, Done, Error, DayOfWeek} !== 6'd0) begin
      testsFailed++;
      $display("FAIL reset_state: got B=%b D=%b E=%b W=%0d, want all 0", Busy, Done, Error, DayOfWeek);
    end
  endtask

  task automatic test_valid();
    int vd[4]  = '{1, 15, 1, 1};
    int vm[4]  = '{1, 3, 3, 1};
    int vy[4]  = '{2000, 2024, 1900, 1};
    logic vl[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] ve[4] = '{3'd6, 3'd5, 3'd4, 3'd1};
    logic b, dn;
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(vd[i], vm[i], vy[i], vl[i], b, dn);
      testsRun++;
      if (b !== 1'b1) begin
        testsFailed++;
        $display("FAIL valid_busy[%0d]: got %b want 1", i, b);
      end
      waitDone(lat);
      testsRun++;
      if (lat !== 35 || Error !== 1'b0 || Busy !== 1'b0 || DayOfWeek !== ve[i]) begin
        testsFailed++;
        $display("FAIL valid[%0d]: got lat=%0d E=%b B=%b W=%0d, want lat=35 E=0 B=0 W=%0d",
                 i, lat, Error, Busy, DayOfWeek, ve[i]);
      end
      lastDow = ve[i];
    end
  endtask

  task automatic test_invalid();
    int vd[5] = '{29, 1, 0, 1, 31};
    int vm[5] = '{2, 13, 5, 1, 4};
    int vy[5] = '{2023, 2023, 2023, 0, 2023};
    logic b, dn;
    int lat;
    for (int i = 0; i < 5; i++) begin
      issue(vd[i], vm[i], vy[i], 1'b0, b, dn);
      waitDone(lat);
      testsRun++;
      if (lat !== 2 || Error !== 1'b1 || Busy !== 1'b0 || DayOfWeek !== lastDow) begin
        testsFailed++;
        $display("FAIL invalid[%0d]: got lat=%0d E=%b B=%b W=%0d, want lat=2 E=1 B=0 W=%0d",
                 i, lat, Error, Busy, DayOfWeek, lastDow);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic b, dn;
    int lat;
    int pulses;
    issue(1, 1, 2000, 1'b1, b, dn);
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    nReset = 1'b0;
    #2;
    testsRun++;
    if (Busy !== 1'b0 || Done !== 1'b0 || DayOfWeek !== 3'd0) begin
      testsFailed++;
      $display("FAIL mid_reset: got B=%b D=%b W=%0d, want 0 0 0", Busy, Done, DayOfWeek);
    end
    @(negedge Clk);
    nReset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk);
      #1;
      if (Done) pulses++;
    end
    testsRun++;
    if (pulses !== 0) begin
      testsFailed++;
      $display("FAIL mid_reset_nodone: got %0d Done pulses, want 0", pulses);
    end
    issue(15, 3, 2024, 1'b1, b, dn);
    waitDone(lat);
    testsRun++;
    if (lat !== 35 || Error !== 1'b0 || DayOfWeek !== 3'd5) begin
      testsFailed++;
      $display("FAIL mid_reset_recover: got lat=%0d E=%b W=%0d, want 35 0 5", lat, Error, DayOfWeek);
    end
  endtask

  task automatic test_boundary();
    logic b, dn;
    int lat;
    issue(31, 12, 32767, 1'b0, b, dn);
    waitDone(lat);
    testsRun++;
    if (lat !== 35 || Error !== 1'b0 || DayOfWeek !== 3'd0) begin
      testsFailed++;
      $display("FAIL boundary_year: got lat=%0d E=%b W=%0d, want 35 0 0", lat, Error, DayOfWeek);
    end
  endtask

  task automatic test_back_to_back();
    logic b, dn;
    int lat;
    int pulses;
    int firstK;
    logic [2:0] firstW;
    // Second Start while busy must be ignored
    issue(1, 1, 2000, 1'b1, b, dn);
    pulses = 0; firstK = -1; firstW = 3'd7;
    for (int k = 1; k <= 80; k++) begin
      @(posedge Clk);
      #1;
      if (Done) begin
        pulses++;
        if (firstK < 0) begin
          firstK = k;
          firstW = DayOfWeek;
        end
      end
      if (k == 5) begin
        Days = 7'd1; Months = 7'd3; Years = 15'd1900; Leap = 1'b0; Start = 1'b1;
      end else begin
        Start = 1'b0;
      end
    end
    testsRun++;
    if (pulses !== 1 || firstK !== 35 || firstW !== 3'd6) begin
      testsFailed++;
      $display("FAIL busy_start_ignored: got pulses=%0d at=%0d W=%0d, want 1 35 6", pulses, firstK, firstW);
    end
    // Start in the Done cycle is accepted
    issue(15, 3, 2024, 1'b1, b, dn);
    waitDone(lat);
    testsRun++;
    if (lat !== 35 || DayOfWeek !== 3'd5) begin
      testsFailed++;
      $display("FAIL b2b_first: got lat=%0d W=%0d, want 35 5", lat, DayOfWeek);
    end
    issue(1, 1, 1, 1'b0, b, dn);
    testsRun++;
    if (b !== 1'b1 || dn !== 1'b0) begin
      testsFailed++;
      $display("FAIL b2b_accept: got B=%b D=%b, want B=1 D=0", b, dn);
    end
    waitDone(lat);
    testsRun++;
    if (lat !== 35 || Error !== 1'b0 || DayOfWeek !== 3'd1) begin
      testsFailed++;
      $display("FAIL b2b_second: got lat=%0d E=%b W=%0d, want 35 0 1", lat, Error, DayOfWeek);
    end
    @(posedge Clk);
    #1;
    testsRun++;
    if (Done !== 1'b0) begin
      testsFailed++;
      $display("FAIL done_single_pulse: got %b want 0", Done);
    end
  endtask

  task automatic test_random();
    logic b, dn;
    int lat;
    int y, m, d;
    logic l;
    logic [2:0] exp;
    for (int i = 0; i < 2000; i++) begin
      y = int'($urandom_range(32767, 1));
      m = int'($urandom_range(12, 1));
      l = isLeap(y);
      d = int'($urandom_range(monLen(m, l), 1));
      exp = goldenDow(d, m, y);
      // Each new request lands in the previous request's Done cycle
      issue(d, m, y, l, b, dn);
      waitDone(lat);
      testsRun++;
      if (lat !== 35 || Error !== 1'b0 || DayOfWeek !== exp) begin
        testsFailed++;
        $display("FAIL random[%0d] %0d-%0d-%0d L=%b: got lat=%0d E=%b W=%0d, want 35 0 %0d",
                 i, y, m, d, l, lat, Error, DayOfWeek, exp);
      end
    end
  endtask

  initial begin
    nReset = 1'b0; Start = 1'b0; Days = 7'd0; Months = 7'd0; Years = 15'd0; Leap = 1'b0;
    lastDow = 3'd0;
    #22;
    test_reset();
    @(negedge Clk);
    nReset = 1'b1;
    test_valid();
    test_invalid();
    test_mid_reset();
    test_boundary();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
